alu_byte_sequencer: RTL and testbench



---
 rtl/alu_byte_sequencer_if.sv | 26 ++
 rtl/alu_byte_sequencer.sv | 109 ++++++++++
 tb/tb_alu_byte_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_byte_sequencer_if.sv
// rtl/alu_byte_sequencer_if.sv - start/busy/done handshake and operand/result bus of the byte-sliced ALU
interface alu_byte_sequencer_if #(
   parameter int XLEN = 32
);
   logic            ena;
   logic            start;
   logic            sub;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            carry;
   logic            zero;
   logic            overflow;

   modport master (
      output ena, start, sub, op_a, op_b,
      input  busy, done, result, carry, zero, overflow
   );

   modport slave (
      input  ena, start, sub, op_a, op_b,
      output busy, done, result, carry, zero, overflow
   );
endinterface

// File: rtl/alu_byte_sequencer.sv
// rtl/alu_byte_sequencer.sv - multi-cycle add/subtract sharing one SLICE-bit adder, LSB slice first
module alu_byte_sequencer #(
   parameter int XLEN  = 32,
   parameter int SLICE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_byte_sequencer_if.slave   bus
);
   localparam int NSLICE = XLEN / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              cin_q, cin_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic              ovf_q, ovf_d;

   logic [SLICE:0]    slice_sum;
   logic [XLEN-1:0]   merged;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cin_d    = cin_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;

      slice_sum = {1'b0, a_q[cnt_q*SLICE +: SLICE]} + {1'b0, b_q[cnt_q*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, cin_q};
      merged = result_q;
      merged[cnt_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];

      if (bus.ena) begin
         unique case (state_q)
            S_RUN: begin
               result_d = merged;
               cin_d    = slice_sum[SLICE];
               if (cnt_q == CW'(NSLICE - 1)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
                  carry_d = slice_sum[SLICE];
                  zero_d  = (merged == '0);
                  ovf_d   = (a_q[XLEN-1] == b_q[XLEN-1]) && (merged[XLEN-1] != a_q[XLEN-1]);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               // subtract is a + ~b + 1: the +1 rides in as the initial carry
               if (bus.start) begin
                  a_d      = bus.op_a;
                  b_d      = bus.sub ? ~bus.op_b : bus.op_b;
                  cin_d    = bus.sub;
                  cnt_d    = '0;
                  result_d = '0;
                  carry_d  = 1'b0;
                  zero_d   = 1'b0;
                  ovf_d    = 1'b0;
                  state_d  = S_RUN;
               end else if (state_q == S_DONE) begin
                  state_d = S_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cin_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cin_q    <= cin_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy     = (state_q == S_RUN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.result   = result_q;
   assign bus.carry    = carry_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb/tb_alu_byte_sequencer.sv - scoreboard bench for alu_byte_sequencer against an arithmetic reference
module tb_alu_byte_sequencer;
   localparam int XLEN   = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = XLEN / SLICE;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_byte_sequencer_if #(.XLEN(XLEN)) ifc ();

   alu_byte_sequencer #(.XLEN(XLEN), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   typedef struct {
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        v;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   checks = 0;
   int   errors = 0;
   int   en_edge = 0;
   int   raw_edge = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) begin
      raw_edge++;
      if (rst_n && ifc.ena) en_edge++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t   e;
      logic [32:0] w;
      longint sa, sbv, t;
      w   = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      t   = s ? sa - sbv : sa + sbv;
      e.r = w[31:0];
      e.c = w[32];
      e.z = (w[31:0] == 32'd0);
      e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      e.due = 0;
      return e;
   endfunction

   // Monitor: pops one expectation on every rising edge of done
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_done = 1'b0;
         last = '{r: 32'd0, c: 1'b0, z: 1'b0, v: 1'b0, due: 0};
      end else begin
         chk("busy_done_excl", {62'd0, ifc.busy, ifc.done} == 64'd3, 1'b0);
         if (ifc.done && !prev_done) begin
            chk("sb_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("result", ifc.result, e.r);
               chk("carry", ifc.carry, e.c);
               chk("zero", ifc.zero, e.z);
               chk("overflow", ifc.overflow, e.v);
               chk("latency", en_edge, e.due);
               last = e;
            end
         end else if (!ifc.busy && !ifc.done) begin
            chk("idle_hold", {ifc.result, ifc.carry, ifc.zero, ifc.overflow},
                {last.r, last.c, last.z, last.v});
         end
         prev_done = ifc.done;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      ifc.op_a  = a;
      ifc.op_b  = b;
      ifc.sub   = s;
      ifc.start = 1'b1;
      ifc.ena   = 1'b1;
      @(posedge clk);
      #1;
      e = model(a, b, s);
      e.due = en_edge + NSLICE;
      sb.push_back(e);
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.op_a  = $urandom;
      ifc.op_b  = $urandom;
      ifc.sub   = 1'($urandom_range(0, 1));
      chk("accept_busy", {ifc.busy, ifc.done}, 2'b10);
   endtask

   task automatic wait_done(input bit rand_ena);
      int n = 0;
      while (!ifc.done && n < 200) begin
         chk("run_busy", ifc.busy, 1'b1);
         if (rand_ena) ifc.ena = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n++;
      end
      chk("done_timeout", ifc.done, 1'b1);
      ifc.ena = 1'b1;
   endtask

   task automatic run_directed(input logic [31:0] a, input logic [31:0] b, input logic s);
      start_op(a, b, s);
      wait_done(1'b0);
      @(negedge clk);
      chk("done_one_cycle", ifc.done, 1'b0);
   endtask

   initial begin
      int r0;
      rst_n     = 1'b0;
      ifc.ena   = 1'b0;
      ifc.start = 1'b0;
      ifc.sub   = 1'b0;
      ifc.op_a  = '0;
      ifc.op_b  = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {ifc.busy, ifc.done, ifc.result, ifc.carry, ifc.zero, ifc.overflow}, 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      ifc.ena = 1'b1;
      @(negedge clk);

      run_directed(32'h0000_00FF, 32'h0000_0001, 1'b0);
      run_directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_directed(32'h8000_0000, 32'h0000_0001, 1'b1);

      // back-to-back: new start issued in the DONE cycle
      start_op(32'h0000_0005, 32'h0000_0007, 1'b1);
      wait_done(1'b0);
      start_op(32'h0000_0003, 32'h0000_0004, 1'b0);
      wait_done(1'b0);
      @(negedge clk);

      // stall for 3 cycles after slice 1, with a start pulse during RUN
      start_op(32'h1234_0000, 32'h0000_FFFF, 1'b0);
      r0 = raw_edge;
      ifc.start = 1'b1;
      ifc.op_a  = 32'hDEAD_BEEF;
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.ena   = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_busy", ifc.busy, 1'b1);
      end
      ifc.ena = 1'b1;
      wait_done(1'b0);
      chk("stall_delay", raw_edge, r0 + NSLICE + 3);
      @(negedge clk);

      // asynchronous reset during slice 2
      start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {ifc.busy, ifc.done, ifc.result, ifc.carry, ifc.zero, ifc.overflow}, 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      run_directed(32'h1234_5678, 32'h1111_1111, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: a = 32'h7FFF_FFFF;
            1: b = 32'h8000_0000;
            2: b = a;
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         start_op(a, b, 1'($urandom_range(0, 1)));
         wait_done(1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (8) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
